// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the async FIFO write side (wclk domain).
// A grant stays locked to one requester until its 'last' beat or MAX_BURST beats have been written.
module fifo_wr_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DSIZE     = 8,
    parameter int unsigned IDW       = 2,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic                  wclk,
    input  logic                  dirclr_n,
    input  logic                  arb_en,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    output logic                  wq,
    output logic [DSIZE-1:0]      write_data,
    output logic                  gnt_valid,
    output logic [IDW-1:0]        gnt_id
);

    localparam int unsigned    BCW        = $clog2(MAX_BURST + 1);
    localparam logic [BCW-1:0] BEAT_FINAL = BCW'(MAX_BURST - 1);
    localparam logic [IDW-1:0] ID_TOP     = IDW'(NREQ - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [BCW-1:0]   beat_cnt;
    logic [DSIZE-1:0] data_arr [NREQ];

    logic             busy;
    logic             accept;
    logic             release_now;
    logic             pick_found;
    logic [IDW-1:0]   pick_id;
    logic [IDW-1:0]   cand;
    logic [IDW-1:0]   next_rr;

    function automatic logic [IDW-1:0] wrap_id(input int unsigned v);
        return IDW'(v % NREQ);
    endfunction

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*DSIZE +: DSIZE];
    end

    assign busy        = (state == BUSY);
    assign wq          = busy & req_valid[gnt_id] & ~wfull;
    assign accept      = wq;
    assign write_data  = data_arr[gnt_id];
    assign release_now = accept & (req_last[gnt_id] | (beat_cnt == BEAT_FINAL));
    assign next_rr     = (gnt_id == ID_TOP) ? '0 : gnt_id + IDW'(1);

    always_comb begin
        req_ready = '0;
        if (busy && !wfull) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = wrap_id(32'(rr_ptr) + k);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_ff @(posedge wclk or negedge dirclr_n) begin
        if (!dirclr_n) begin
            state     <= IDLE;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_en && pick_found) begin
                        state     <= BUSY;
                        gnt_valid <= 1'b1;
                        gnt_id    <= pick_id;
                        beat_cnt  <= '0;
                    end
                end
                BUSY: begin
                    if (accept) begin
                        if (release_now) begin
                            state     <= IDLE;
                            gnt_valid <= 1'b0;
                            rr_ptr    <= next_rr;
                            beat_cnt  <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + BCW'(1);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: queue-based sources, a log of FIFO writes,
// and hand-derived expected grant timing and FIFO contents.
module tb_fifo_wr_arbiter;

    logic        wclk = 1'b0;
    logic        dirclr_n;
    logic        arb_en;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        wfull;
    logic        wq;
    logic [7:0]  write_data;
    logic        gnt_valid;
    logic [1:0]  gnt_id;

    int          checks = 0;
    int          errors = 0;

    logic [8:0]  src_q [4][$];
    logic [7:0]  log_q [$];
    logic [7:0]  exp_q [$];
    logic [3:0]  acc;

    fifo_wr_arbiter #(
        .NREQ      (4),
        .DSIZE     (8),
        .IDW       (2),
        .MAX_BURST (8)
    ) dut (
        .wclk       (wclk),
        .dirclr_n   (dirclr_n),
        .arb_en     (arb_en),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .wfull      (wfull),
        .wq         (wq),
        .write_data (write_data),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        logic [8:0] head;
        for (int i = 0; i < 4; i++) begin
            if (src_q[i].size() > 0) begin
                head             = src_q[i][0];
                req_valid[i]     = 1'b1;
                req_last[i]      = head[8];
                req_data[i*8+:8] = head[7:0];
            end else begin
                req_valid[i]     = 1'b0;
                req_last[i]      = 1'b0;
                req_data[i*8+:8] = '0;
            end
        end
    endtask

    task automatic push_beat(input int r, input logic last, input logic [7:0] d);
        src_q[r].push_back({last, d});
    endtask

    // Sample at the edge (log writes, note accepts), then update sources 1 time unit later.
    task automatic tick();
        @(posedge wclk);
        acc = req_valid & req_ready;
        if (wq) log_q.push_back(write_data);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) void'(src_q[i].pop_front());
        end
        refresh();
    endtask

    task automatic check_log(input string tag);
        check({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < log_q.size()) check({tag, "_dat"}, 32'(log_q[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic do_reset();
        dirclr_n = 1'b0;
        for (int i = 0; i < 4; i++) src_q[i].delete();
        refresh();
        wfull  = 1'b0;
        arb_en = 1'b1;
        #1;
        check("rst_gnt_valid", 32'(gnt_valid), 0);
        check("rst_wq", 32'(wq), 0);
        tick();
        tick();
        dirclr_n = 1'b1;
        log_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int ids [5];
        ids = '{0, 1, 2, 3, 0};
        dirclr_n = 1'b0;
        arb_en   = 1'b1;
        wfull    = 1'b0;
        acc      = '0;
        for (int i = 0; i < 4; i++) push_beat(i, 1'b1, 8'h55);
        refresh();

        // Reset held with every requester valid
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            check("t1_wq", 32'(wq), 0);
            check("t1_ready", 32'(req_ready), 0);
            check("t1_gnt_valid", 32'(gnt_valid), 0);
            check("t1_gnt_id", 32'(gnt_id), 0);
        end

        // Round robin over single-beat packets
        do_reset();
        push_beat(0, 1'b1, 8'h10);
        push_beat(1, 1'b1, 8'h11);
        push_beat(2, 1'b1, 8'h12);
        push_beat(3, 1'b1, 8'h13);
        push_beat(0, 1'b1, 8'h14);
        refresh();
        for (int k = 1; k <= 10; k++) begin
            tick();
            #1;
            if (k % 2 == 1) begin
                check("t2_gnt_valid", 32'(gnt_valid), 1);
                check("t2_gnt_id", 32'(gnt_id), 32'(ids[(k-1)/2]));
                check("t2_wq", 32'(wq), 1);
                check("t2_ready", 32'(req_ready), 32'(1) << ids[(k-1)/2]);
                check("t2_wdata", 32'(write_data), 32'('h10 + (k-1)/2));
            end else begin
                check("t2_idle_gnt", 32'(gnt_valid), 0);
                check("t2_idle_wq", 32'(wq), 0);
            end
        end
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        check_log("t2_log");

        // Packet lock
        do_reset();
        push_beat(0, 1'b0, 8'hA1);
        push_beat(0, 1'b0, 8'hA2);
        push_beat(0, 1'b1, 8'hA3);
        push_beat(1, 1'b1, 8'hB1);
        refresh();
        for (int k = 1; k <= 7; k++) begin
            tick();
            #1;
            if (k == 3) begin
                check("t3_lock_id", 32'(gnt_id), 0);
                check("t3_lock_ready", 32'(req_ready), 32'h1);
            end
            if (k == 5) check("t3_next_id", 32'(gnt_id), 1);
        end
        exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hB1};
        check_log("t3_log");

        // Full stall after the second beat
        do_reset();
        push_beat(0, 1'b0, 8'hC1);
        push_beat(0, 1'b0, 8'hC2);
        push_beat(0, 1'b1, 8'hC3);
        refresh();
        tick();
        #1;
        check("t4_first_wq", 32'(wq), 1);
        check("t4_first_dat", 32'(write_data), 32'hC1);
        tick();
        tick();
        wfull = 1'b1;
        for (int j = 0; j < 5; j++) begin
            #1;
            check("t4_stall_wq", 32'(wq), 0);
            check("t4_stall_ready", 32'(req_ready), 0);
            check("t4_stall_gnt", 32'(gnt_valid), 1);
            tick();
        end
        wfull = 1'b0;
        #1;
        check("t4_resume_wq", 32'(wq), 1);
        check("t4_resume_dat", 32'(write_data), 32'hC3);
        tick();
        #1;
        check("t4_release", 32'(gnt_valid), 0);
        exp_q = '{8'hC1, 8'hC2, 8'hC3};
        check_log("t4_log");

        // Forced release at MAX_BURST
        do_reset();
        for (int n = 0; n < 12; n++) push_beat(2, 1'b0, 8'(8'h20 + n));
        push_beat(3, 1'b1, 8'h30);
        refresh();
        for (int k = 1; k <= 18; k++) begin
            tick();
            #1;
            if (k == 8) begin
                check("t5_b8_id", 32'(gnt_id), 2);
                check("t5_b8_dat", 32'(write_data), 32'h27);
            end
            if (k == 9) check("t5_forced_idle", 32'(gnt_valid), 0);
            if (k == 10) check("t5_req3_id", 32'(gnt_id), 3);
            if (k == 12) check("t5_req2_again", 32'(gnt_id), 2);
        end
        check("t5_held_gnt", 32'(gnt_valid), 1);
        exp_q = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27,
                  8'h30, 8'h28, 8'h29, 8'h2A, 8'h2B};
        check_log("t5_log");

        // arb_en dropped mid-packet (reset here also drops the held grant)
        do_reset();
        push_beat(1, 1'b0, 8'hE1);
        push_beat(1, 1'b0, 8'hE2);
        push_beat(1, 1'b1, 8'hE3);
        refresh();
        tick();
        arb_en = 1'b0;
        push_beat(0, 1'b1, 8'hF0);
        refresh();
        #1;
        check("t6_gnt_valid", 32'(gnt_valid), 1);
        check("t6_gnt_id", 32'(gnt_id), 1);
        tick();
        #1;
        check("t6_finishing", 32'(gnt_valid), 1);
        for (int k = 3; k <= 7; k++) begin
            tick();
            #1;
            if (k >= 4) check("t6_held_idle", 32'(gnt_valid), 0);
        end
        arb_en = 1'b1;
        tick();
        #1;
        check("t6_regrant", 32'(gnt_valid), 1);
        check("t6_regrant_id", 32'(gnt_id), 0);
        tick();
        exp_q = '{8'hE1, 8'hE2, 8'hE3, 8'hF0};
        check_log("t6_log");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
